phase_detector_bb: RTL and testbench

Parametrised bang-bang/linear phase-frequency detector for the ADPLL loop, replacing the fixed-configuration phase detector. It synchronises the reference and generated clocks into the FPGA clock domain and measures the signed delay between matching rising edges in FPGA clock cycles. It adds behaviour the previous block lacked:

- configurable synchroniser depth;
- a per-measurement valid strobe;
- saturation;
- cycle-slip (frequency) detection;
- a lock indicator.

Its output drives the loop filter directly.

---
 rtl/phase_detector_bb.sv | 174 +++++++++++++++++
 tb/tb_phase_detector_bb.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/phase_detector_bb.sv
// phase_detector_bb: bang-bang/linear phase-frequency detector for the ADPLL.
// Measures signed edge delay in fpga_clk_i cycles, with slip and lock flags.
module phase_detector_bb #(
    parameter int WIDTH       = 20,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_COUNT  = 8
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    reference_i,
    input  logic                    generated_i,
    output logic signed [WIDTH-1:0] pd_clock_cycles_o,
    output logic                    pd_valid_o,
    output logic                    slip_o,
    output logic                    lock_o
);

    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] TOL  = WIDTH'(LOCK_TOL);
    localparam logic [LW-1:0]    LCNT = LW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        REF_LEAD,
        GEN_LEAD
    } state_t;

    logic [SYNC_STAGES-1:0] ref_sync;
    logic [SYNC_STAGES-1:0] gen_sync;
    logic                   ref_dly;
    logic                   gen_dly;
    logic                   ref_e;
    logic                   gen_e;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] emit_v;
    logic [WIDTH-1:0] mag;
    logic             emit;
    logic             slip_n;
    logic [LW-1:0]    lock_cnt;
    logic [LW-1:0]    lock_cnt_n;

    // Input synchronisers plus one delay flop for rising-edge detection.
    always_ff @(posedge fpga_clk_i) begin
        if (!reset_i) begin
            ref_sync <= '0;
            gen_sync <= '0;
            ref_dly  <= 1'b0;
            gen_dly  <= 1'b0;
        end else begin
            ref_sync <= {ref_sync[SYNC_STAGES-2:0], reference_i};
            gen_sync <= {gen_sync[SYNC_STAGES-2:0], generated_i};
            ref_dly  <= ref_sync[SYNC_STAGES-1];
            gen_dly  <= gen_sync[SYNC_STAGES-1];
        end
    end

    assign ref_e = ref_sync[SYNC_STAGES-1] & ~ref_dly;
    assign gen_e = gen_sync[SYNC_STAGES-1] & ~gen_dly;

    assign count_inc = (count == MAX) ? count : count + WIDTH'(1);

    // Measurement FSM: window open/close, emitted value and slip detection.
    always_comb begin
        state_n = state;
        count_n = count;
        emit    = 1'b0;
        emit_v  = '0;
        mag     = '0;
        slip_n  = 1'b0;
        case (state)
            IDLE: begin
                if (ref_e && gen_e) begin
                    emit = 1'b1;
                end else if (ref_e) begin
                    state_n = REF_LEAD;
                    count_n = WIDTH'(1);
                end else if (gen_e) begin
                    state_n = GEN_LEAD;
                    count_n = WIDTH'(1);
                end
            end
            REF_LEAD: begin
                if (gen_e) begin
                    emit   = 1'b1;
                    emit_v = count;
                    mag    = count;
                    if (ref_e) begin
                        count_n = WIDTH'(1);
                    end else begin
                        state_n = IDLE;
                        count_n = '0;
                    end
                end else if (ref_e) begin
                    emit    = 1'b1;
                    emit_v  = MAX;
                    mag     = MAX;
                    slip_n  = 1'b1;
                    count_n = WIDTH'(1);
                end else begin
                    count_n = count_inc;
                end
            end
            GEN_LEAD: begin
                if (ref_e) begin
                    emit   = 1'b1;
                    emit_v = '0 - count;
                    mag    = count;
                    if (gen_e) begin
                        count_n = WIDTH'(1);
                    end else begin
                        state_n = IDLE;
                        count_n = '0;
                    end
                end else if (gen_e) begin
                    emit    = 1'b1;
                    emit_v  = '0 - MAX;
                    mag     = MAX;
                    slip_n  = 1'b1;
                    count_n = WIDTH'(1);
                end else begin
                    count_n = count_inc;
                end
            end
            default: begin
                state_n = IDLE;
                count_n = '0;
            end
        endcase
    end

    // Lock qualifier: consecutive in-tolerance, slip-free measurements.
    always_comb begin
        lock_cnt_n = lock_cnt;
        if (emit) begin
            if (!slip_n && (mag <= TOL)) begin
                lock_cnt_n = (lock_cnt == LCNT) ? lock_cnt
                                                : lock_cnt + LW'(1);
            end else begin
                lock_cnt_n = '0;
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge fpga_clk_i) begin
        if (!reset_i) begin
            state             <= IDLE;
            count             <= '0;
            lock_cnt          <= '0;
            pd_clock_cycles_o <= '0;
            pd_valid_o        <= 1'b0;
            slip_o            <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            lock_cnt   <= lock_cnt_n;
            pd_valid_o <= emit;
            slip_o     <= slip_n;
            if (emit) begin
                pd_clock_cycles_o <= emit_v;
            end
        end
    end

    assign lock_o = (lock_cnt == LCNT);

endmodule

// File: tb/tb_phase_detector_bb.sv
// tb_phase_detector_bb: directed bench for phase_detector_bb.
// Emits are logged by a monitor and compared to hand-computed values.
module tb_phase_detector_bb;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ref_in;
    logic              gen_in;
    logic signed [7:0] pd;
    logic              pd_valid;
    logic              slip;
    logic              lock;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int stray_slip  = 0;

    typedef struct {
        logic signed [7:0] v;
        int                c;
        logic              s;
        logic              l;
    } ev_t;

    ev_t q[$];

    phase_detector_bb #(
        .WIDTH      (8),
        .SYNC_STAGES(2),
        .LOCK_TOL   (2),
        .LOCK_COUNT (8)
    ) dut (
        .fpga_clk_i       (clk),
        .reset_i          (rst_n),
        .reference_i      (ref_in),
        .generated_i      (gen_in),
        .pd_clock_cycles_o(pd),
        .pd_valid_o       (pd_valid),
        .slip_o           (slip),
        .lock_o           (lock)
    );

    always #5 clk = ~clk;

    // Cycle index, advanced on each active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Log every emitted measurement with its cycle and flags.
    always @(negedge clk) begin
        if (pd_valid === 1'b1) q.push_back('{pd, cyc, slip, lock});
        if (slip === 1'b1 && pd_valid !== 1'b1) stray_slip++;
    end

    task automatic chk(string tag, logic signed [31:0] obs,
                       logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic period(int ro, int go, int len, output int start);
        start = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) start = cyc;
            ref_in = (i >= ro) && (i < ro + len / 2);
            gen_in = (i >= go) && (i < go + len / 2);
        end
    endtask

    task automatic run(int ro, int go, int n, int ev, int lat, string tag);
        int st0;
        int st;
        q.delete();
        st0 = 0;
        for (int r = 0; r < n; r++) begin
            period(ro, go, 100, st);
            if (r == 0) st0 = st;
        end
        idle(3);
        chk({tag, "_count"}, q.size(), n);
        foreach (q[k]) begin
            chk($sformatf("%s_val%0d", tag, k), q[k].v, ev);
        end
        if (q.size() > 0) chk({tag, "_latency"}, q[0].c - st0, lat);
    endtask

    task automatic one(int ro, int go, int ev, int el, string tag);
        int st;
        q.delete();
        period(ro, go, 40, st);
        chk({tag, "_count"}, q.size(), 1);
        if (q.size() > 0) begin
            chk({tag, "_val"}, q[0].v, ev);
            chk({tag, "_lock"}, q[0].l, el);
            chk({tag, "_slip"}, q[0].s, 0);
        end
    endtask

    initial begin
        int errs[8];
        int e;
        errs = '{1, -2, 0, 2, -1, 0, 1, -2};
        rst_n  = 1'b0;
        ref_in = 1'b0;
        gen_in = 1'b0;

        // Reset held while both inputs toggle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_valid", pd_valid, 0);
            chk("rst_pd", pd, 0);
            ref_in = i[0];
            gen_in = ~i[0];
        end
        @(negedge clk);
        ref_in = 1'b0;
        gen_in = 1'b0;
        idle(2);
        q.delete();
        rst_n = 1'b1;
        idle(12);
        chk("post_rst_emits", q.size(), 0);
        chk("post_rst_pd", pd, 0);
        chk("post_rst_slip", slip, 0);
        chk("post_rst_lock", lock, 0);

        // Lead, lag and coincident edges.
        run(0, 7, 3, 7, 10, "lead");
        run(7, 0, 3, -7, 10, "lag");
        idle(10);
        chk("hold_pd", pd, -7);
        run(0, 0, 2, 0, 3, "coinc");

        // Lock acquisition and loss.
        one(0, 5, 5, 0, "lock_clr");
        for (int k = 0; k < 8; k++) begin
            e = errs[k];
            one((e < 0) ? -e : 0, (e > 0) ? e : 0, e, int'(k == 7),
                $sformatf("lock_up%0d", k));
        end
        one(0, 3, 3, 0, "lock_drop");
        for (int k = 0; k < 8; k++) begin
            one(0, 0, 0, int'(k == 7), $sformatf("relock%0d", k));
        end
        chk("relocked", lock, 1);

        // Cycle slip: two ref edges, then gen 3 cycles after the second.
        q.delete();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            ref_in = (i < 5) || (i >= 20 && i < 25);
            gen_in = (i >= 23) && (i < 30);
        end
        chk("slip_count", q.size(), 2);
        if (q.size() == 2) begin
            chk("slip_val", q[0].v, 127);
            chk("slip_flag", q[0].s, 1);
            chk("slip_lock", q[0].l, 0);
            chk("after_slip_val", q[1].v, 3);
            chk("after_slip_flag", q[1].s, 0);
        end

        // Saturation: 300-cycle lead on an 8-bit counter.
        q.delete();
        for (int i = 0; i < 330; i++) begin
            @(negedge clk);
            ref_in = (i < 10);
            gen_in = (i >= 300) && (i < 315);
        end
        chk("sat_count", q.size(), 1);
        if (q.size() > 0) begin
            chk("sat_val", q[0].v, 127);
            chk("sat_slip", q[0].s, 0);
        end

        // Reset mid-window discards the pending ref edge.
        q.delete();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 6) chk("midrst_pd", pd, 0);
            rst_n  = (i != 4);
            ref_in = (i < 4) || (i >= 15 && i < 22);
            gen_in = (i >= 10) && (i < 20);
        end
        chk("midrst_count", q.size(), 1);
        if (q.size() > 0) chk("midrst_val", q[0].v, -5);
        one(0, 4, 4, 0, "final_pair");

        chk("stray_slip", stray_slip, 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
